// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement magnitude when treated as signed, pass-through otherwise.
  // 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v,
                                                 input logic             as_signed);
    return (as_signed && v[DIV_W-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/iter_divider.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle.
// Fixed latency: accepted on edge 0, result valid for the cycle after edge 33.
// Result format is {quotient, remainder}; a zero divisor gives an all-ones
// quotient and the original dividend as remainder.
module iter_divider
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     s_axis_divisor_tdata,
  input  logic                  s_axis_divisor_tvalid,
  output logic                  s_axis_divisor_tready,
  input  logic [DATA_W-1:0]     s_axis_dividend_tdata,
  input  logic                  s_axis_dividend_tvalid,
  output logic                  s_axis_dividend_tready,
  input  logic                  s_signed,
  output logic [2*DATA_W-1:0]   m_axis_dout_tdata,
  output logic                  m_axis_dout_tvalid
);

  state_t              state;
  logic [5:0]          count;
  logic                signed_mode;
  logic                q_neg_raw;
  logic                r_neg_raw;
  logic                div_zero;
  logic [DATA_W-1:0]   divisor_mag;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  logic                accept;
  logic [DATA_W:0]     rem_shift;
  logic [DATA_W:0]     rem_sub;
  logic                fits;
  logic [DATA_W-1:0]   q_final;
  logic [DATA_W-1:0]   r_final;

  assign s_axis_divisor_tready  = (state == IDLE);
  assign s_axis_dividend_tready = (state == IDLE);
  assign accept = (state == IDLE) && s_axis_divisor_tvalid && s_axis_dividend_tvalid;

  // One restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor if it fits.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    rem_shift = '0;
    rem_sub   = '0;
    fits      = 1'b0;
    rem_shift = {rem, quo[DATA_W-1]};
    rem_sub   = rem_shift - {1'b0, divisor_mag};
    fits      = (rem_shift >= {1'b0, divisor_mag});
  end

  // Sign post-conditioning and the zero-divisor override.
  always_comb begin
    q_final = quo;
    r_final = rem;
    if (signed_mode && q_neg_raw) q_final = ~quo + 1'b1;
    if (signed_mode && r_neg_raw) r_final = ~rem + 1'b1;
    if (div_zero)                 q_final = '1;
  end

  // Control FSM, iteration datapath and registered result.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state              <= IDLE;
      count              <= '0;
      m_axis_dout_tvalid <= 1'b0;
      m_axis_dout_tdata  <= '0;
    end else begin
      m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= BUSY;
            count <= '0;
          end
        end
        BUSY: begin
          count <= count + 1'b1;
          if (count == 6'(DIV_ITERS - 1)) state <= DONE;
        end
        DONE: begin
          state              <= IDLE;
          m_axis_dout_tvalid <= 1'b1;
          m_axis_dout_tdata  <= {q_final, r_final};
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and iteration registers; their contents are meaningless outside
  // BUSY/DONE, so they carry no reset.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are deliberately left unreset; only control
    // state and the visible outputs need a defined reset value.
    if (!reset) begin
      if (accept) begin
        signed_mode <= s_signed;
        q_neg_raw   <= s_axis_dividend_tdata[DATA_W-1] ^ s_axis_divisor_tdata[DATA_W-1];
        r_neg_raw   <= s_axis_dividend_tdata[DATA_W-1];
        div_zero    <= (s_axis_divisor_tdata == '0);
        divisor_mag <= magnitude(s_axis_divisor_tdata, s_signed);
        quo         <= magnitude(s_axis_dividend_tdata, s_signed);
        rem         <= '0;
      end else if (state == BUSY) begin
        quo <= {quo[DATA_W-2:0], fits};
        rem <= fits ? rem_sub[DATA_W-1:0] : rem_shift[DATA_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on every tvalid pulse.
module tb_iter_divider;

  localparam int LAT = 33;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        sgn;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] divisor_tdata;
  logic        divisor_tvalid;
  logic        divisor_tready;
  logic [31:0] dividend_tdata;
  logic        dividend_tvalid;
  logic        dividend_tready;
  logic        s_signed;
  logic [63:0] dout_tdata;
  logic        dout_tvalid;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb[$];
  logic [63:0] last_exp = '0;

  iter_divider #(.DATA_W(32)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_divisor_tdata   (divisor_tdata),
    .s_axis_divisor_tvalid  (divisor_tvalid),
    .s_axis_divisor_tready  (divisor_tready),
    .s_axis_dividend_tdata  (dividend_tdata),
    .s_axis_dividend_tvalid (dividend_tvalid),
    .s_axis_dividend_tready (dividend_tready),
    .s_signed               (s_signed),
    .m_axis_dout_tdata      (dout_tdata),
    .m_axis_dout_tvalid     (dout_tvalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, exp);
    end
  endtask

  // Monitor: result pulses against the scoreboard, tdata hold otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      last_exp = '0;
    end else if (dout_tvalid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_tvalid", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result_data", dout_tdata, e.data);
        check("result_cycle", 64'(cyc), 64'(e.cyc));
        last_exp = e.data;
      end
    end else begin
      check("tdata_hold", dout_tdata, last_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic va, input logic vb);
    dividend_tdata  = a;
    divisor_tdata   = b;
    s_signed        = s;
    dividend_tvalid = va;
    divisor_tvalid  = vb;
  endtask

  // Present one operand pair for a single cycle; acceptance on the next edge.
  task automatic send(input vec_t v);
    check("idle_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);
    drive(v.dividend, v.divisor, v.sgn, 1'b1, 1'b1);
    sb.push_back('{data: v.exp, cyc: cyc + 1 + LAT});
    step();
    check("accepted_ready_low", {62'd0, dividend_tready, divisor_tready}, 64'd0);
    dividend_tvalid = 1'b0;
    divisor_tvalid  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    step();
  endtask

  vec_t vecs[] = '{
    '{32'd7,        32'd2,        1'b0, {32'h00000003, 32'h00000001}},
    '{32'hFFFFFFF9, 32'd2,        1'b1, {32'hFFFFFFFD, 32'hFFFFFFFF}},
    '{32'hFFFFFFF9, 32'd2,        1'b0, {32'h7FFFFFFC, 32'h00000001}},
    '{32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h00000000}},
    '{32'd5,        32'd0,        1'b0, {32'hFFFFFFFF, 32'h00000005}},
    '{32'd5,        32'd0,        1'b1, {32'hFFFFFFFF, 32'h00000005}},
    '{32'hFFFFFFF9, 32'd0,        1'b1, {32'hFFFFFFFF, 32'hFFFFFFF9}},
    '{32'd100,      32'hFFFFFFF9, 1'b1, {32'hFFFFFFF2, 32'h00000002}},
    '{32'hFFFFFF9C, 32'd7,        1'b1, {32'hFFFFFFF2, 32'hFFFFFFFE}},
    '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, {32'h00000001, 32'h00000000}},
    '{32'h80000000, 32'd1,        1'b1, {32'h80000000, 32'h00000000}},
    '{32'h12345678, 32'h10,       1'b0, {32'h01234567, 32'h00000008}}
  };

  initial begin
    int e0;
    reset = 1'b1;
    drive('0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset state.
    check("reset_tvalid", {63'd0, dout_tvalid}, 64'd0);
    check("reset_tdata", dout_tdata, 64'd0);
    check("reset_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);

    // Directed vectors, one at a time.
    foreach (vecs[i]) begin
      send(vecs[i]);
      drain();
    end

    // Dividend valid alone must not be accepted; latency counts from the joint edge.
    drive(32'h20, 32'h5, 1'b0, 1'b1, 1'b0);
    repeat (5) begin
      step();
      check("single_valid_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);
    end
    send('{32'h20, 32'h5, 1'b0, {32'h00000006, 32'h00000002}});
    drain();

    // Valids held through BUSY, operands changed mid-flight: back-to-back results.
    drive(32'hFFFFFFF0, 32'h10, 1'b0, 1'b1, 1'b1);
    sb.push_back('{data: {32'h0FFFFFFF, 32'h00000000}, cyc: cyc + 1 + LAT});
    step();
    e0 = cyc;
    drive(32'hDEADBEEF, 32'h100, 1'b1, 1'b1, 1'b1);
    sb.push_back('{data: {32'h00DEADBE, 32'h000000EF}, cyc: e0 + LAT + 1 + LAT});
    while (cyc <= e0 + LAT - 1) begin
      check("busy_ready_low", {62'd0, dividend_tready, divisor_tready}, 64'd0);
      if (cyc == e0 + 20) s_signed = 1'b0;
      step();
    end
    check("b2b_idle_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);
    step();
    check("b2b_second_accept", {62'd0, dividend_tready, divisor_tready}, 64'd0);
    dividend_tvalid = 1'b0;
    divisor_tvalid  = 1'b0;
    drain();

    // Reset wins over acceptance in the same cycle.
    drive(32'd50, 32'd5, 1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    dividend_tvalid = 1'b0;
    divisor_tvalid  = 1'b0;
    check("reset_priority_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);
    step();
    check("reset_priority_idle", {62'd0, dividend_tready, divisor_tready}, 64'd3);

    // Reset during BUSY iteration 10 aborts with no pulse.
    drive(32'd100, 32'd7, 1'b0, 1'b1, 1'b1);
    step();
    e0 = cyc;
    dividend_tvalid = 1'b0;
    divisor_tvalid  = 1'b0;
    while (cyc < e0 + 9) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_tvalid", {63'd0, dout_tvalid}, 64'd0);
    check("abort_tdata", dout_tdata, 64'd0);
    check("abort_ready", {62'd0, dividend_tready, divisor_tready}, 64'd3);
    repeat (40) step();
    send('{32'd9, 32'd3, 1'b0, {32'h00000003, 32'h00000000}});
    drain();

    repeat (40) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
